// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Instruction-fetch front end. Owns the fetch PC, issues word
//               requests over a req/gnt + rvalid handshake with up to DEPTH
//               requests in flight, buffers returned words with their PCs in
//               a DEPTH-entry queue feeding decode, and handles redirects by
//               flushing the queue and discarding stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int              N        = 32,
    parameter int              DEPTH    = 4,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect_valid,
    input  logic [N-1:0]  redirect_pc,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst_data,
    output logic [N-1:0]  inst_pc
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam int                 c_cnt_w   = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [N-1:0]       c_pc_step = N'(4);

    // Architectural state
    logic [N-1:0]         r_fetch_pc;
    logic [N-1:0]         r_resp_pc;
    logic [c_cnt_w-1:0]   r_outstanding;
    logic [c_cnt_w-1:0]   r_drop_cnt;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [N-1:0]         r_q_pc   [DEPTH];
    logic [31:0]          r_q_data [DEPTH];

    // Per-cycle events
    logic [c_cnt_w:0]     w_credit_used;
    logic                 w_issue;
    logic                 w_resp;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic [N-1:0]         w_redirect_pc;
    logic                 w_unused_align;

    // Queue entries plus requests in flight never exceed DEPTH, so every
    // response is guaranteed a free slot when it arrives.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};

    assign imem_req   = reset && !redirect_valid && (w_credit_used < c_depth);
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0) && !redirect_valid;
    assign inst_data  = r_q_data[r_rd_ptr];
    assign inst_pc    = r_q_pc[r_rd_ptr];

    assign w_issue = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp  = imem_rvalid && (r_outstanding != '0);
    assign w_drop  = w_resp && (r_drop_cnt != '0);
    // A response arriving in a redirect cycle belongs to the old stream.
    assign w_push  = w_resp && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop   = inst_valid && inst_ready;

    // Misaligned redirect targets are silently forced to a word boundary.
    assign w_redirect_pc  = {redirect_pc[N-1:2], 2'b00};
    assign w_unused_align = ^redirect_pc[1:0];

    // Fetch PC, response PC and in-flight / discard bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            case ({w_issue, w_resp})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_one;
                2'b01:   r_outstanding <= r_outstanding - c_cnt_one;
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                // Everything still in flight, minus any response consumed
                // this very cycle, belongs to the abandoned stream.
                r_drop_cnt <= r_outstanding - {{(c_cnt_w-1){1'b0}}, w_resp};
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + c_pc_step;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_one;
                end
            end
        end
    end

    // Queue pointers and occupancy; a redirect flushes by snapping rd to wr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are only meaningful while counted as valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
            r_q_data[r_wr_ptr] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    // Flag responses that arrive with no request outstanding
    a_no_spurious_rvalid : assert property (
        @(posedge clk) disable iff (!reset)
        imem_rvalid |-> (r_outstanding != '0)
    ) else $error("if_fetch_queue: imem_rvalid with no outstanding request");
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Self-checking bench for if_fetch_queue. An in-order memory
//               model answers grants with random latency; a scoreboard holds
//               the expected program-order PC stream (rebuilt on every
//               redirect or reset) and a monitor pops it on each delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int          N        = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    if_fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          grant_cnt = 0;
    int          delivered = 0;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];
    logic        pend_redirect = 1'b0;
    logic [31:0] pend_target = '0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream after a redirect/reset: consecutive words from start
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // One clock cycle: drive inputs after the edge, then record handshakes
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic gnt,
                         input logic rdy, input int lat);
        int d;
        @(posedge clk);
        #1;
        reset = 1'b1;
        if (pend_redirect) begin
            load_stream(pend_target);
            pend_redirect = 1'b0;
        end
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_gnt       = gnt;
        inst_ready     = rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #2;
        if (prev_req && !prev_gnt && imem_req) check("addr_hold", imem_addr, prev_addr);
        if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (rd) begin
            pend_redirect = 1'b1;
            pend_target   = {rpc[31:2], 2'b00};
        end
        if (imem_rvalid) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{imem_addr, d});
            grant_cnt++;
        end
        check("inflight_le_depth", 32'(mem_q.size() <= DEPTH), 32'h1);
        prev_req  = imem_req;
        prev_gnt  = imem_gnt;
        prev_addr = imem_addr;
        cyc++;
    endtask

    // Two reset cycles with grant offered; memory forgets in-flight work too
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        inst_ready     = 1'b0;
        mem_q.delete();
        pend_redirect  = 1'b0;
        last_due       = 0;
        prev_req       = 1'b0;
        load_stream(RESET_PC);
        for (int k = 0; k < 2; k++) begin
            if (k != 0) begin
                @(posedge clk);
                #1;
            end
            #2;
            check("rst_req", {31'b0, imem_req}, 32'h0);
            check("rst_valid", {31'b0, inst_valid}, 32'h0);
            check("rst_addr", imem_addr, RESET_PC);
        end
    endtask

    // Run until the head is valid (bounded), then check it
    task automatic wait_first(input string nm, input logic [31:0] pc);
        for (int k = 0; k < 20 && !inst_valid; k++) cycle(1'b0, '0, 1'b1, 1'b1, 3);
        check({nm, "_valid"}, {31'b0, inst_valid}, 32'h1);
        check({nm, "_pc"}, inst_pc, pc);
        check({nm, "_data"}, inst_data, pc ^ KEY);
    endtask

    // Scoreboard monitor: every accepted instruction pops one expectation
    always @(negedge clk) begin
        if (reset) begin
            if (redirect_valid) check("valid_in_redirect", {31'b0, inst_valid}, 32'h0);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got pc %h expected none", inst_pc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("inst_pc", inst_pc, mon_exp);
                    check("inst_data", inst_data, mon_exp ^ KEY);
                end
                seen_q.push_back(inst_pc);
                delivered++;
            end
        end
    end

    initial begin
        int since;
        int base;
        logic        rd;
        logic [31:0] tgt;

        // Reset and streaming at full rate
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("rel_req", {31'b0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, RESET_PC);
        check("rel_valid0", {31'b0, inst_valid}, 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("rel_valid1", {31'b0, inst_valid}, 32'h0);
        for (int i = 2; i < 12; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b1, 1);
            check("stream_valid", {31'b0, inst_valid}, 32'h1);
            check("stream_pc", inst_pc, RESET_PC + 32'(4 * (i - 2)));
        end

        // Backpressure: credits stop issue at DEPTH, drain restores it
        do_reset();
        grant_cnt = 0;
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0, 1);
        check("bp_grants", 32'(grant_cnt), 32'(DEPTH));
        check("bp_req_off", {31'b0, imem_req}, 32'h0);
        check("bp_head_pc", inst_pc, RESET_PC);
        seen_q.delete();
        cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("bp_req_first_pop", {31'b0, imem_req}, 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("bp_req_back", {31'b0, imem_req}, 32'h1);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("bp_seen_cnt", 32'(seen_q.size() >= 4), 32'h1);
        for (int k = 0; k < 4 && k < seen_q.size(); k++)
            check("bp_order", seen_q[k], RESET_PC + 32'(4 * k));

        // Redirect with two requests in flight (3-cycle latency)
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1, 3);
        cycle(1'b0, '0, 1'b1, 1'b1, 3);
        check("rd_inflight", 32'(mem_q.size()), 32'h2);
        cycle(1'b1, 32'h100, 1'b1, 1'b1, 3);
        check("rd_req_off", {31'b0, imem_req}, 32'h0);
        check("rd_valid_off", {31'b0, inst_valid}, 32'h0);
        wait_first("rd_first", 32'h100);

        // Misaligned redirect followed by a grant stall
        cycle(1'b1, 32'h102, 1'b1, 1'b1, 2);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 2);
            check("stall_req", {31'b0, imem_req}, 32'h1);
            check("stall_addr", imem_addr, 32'h100);
        end
        wait_first("mis_first", 32'h100);

        // PC wrap through zero
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
        seen_q.delete();
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("wrap_cnt", 32'(seen_q.size() >= 4), 32'h1);
        for (int k = 0; k < 4 && k < seen_q.size(); k++)
            check("wrap_pc", seen_q[k], 32'hFFFF_FFF8 + 32'(4 * k));

        // Randomised traffic with redirects, stalls, latency and backpressure
        base  = delivered;
        since = 0;
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 39) == 0) || (since >= 200);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2:       tgt = $urandom & 32'h0000_0FFF;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            since = rd ? 0 : since + 1;
            cycle(rd, tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(1, 4));
        end
        repeat (30) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        check("rand_progress", 32'((delivered - base) > 300), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
